// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: immediate-type codes, major opcodes,
// decode-stage FSM states and the decoded entry carried toward execute.
package rv32i_pkg;

   localparam logic [2:0] IMM_I    = 3'b000;
   localparam logic [2:0] IMM_S    = 3'b001;
   localparam logic [2:0] IMM_B    = 3'b010;
   localparam logic [2:0] IMM_U    = 3'b011;
   localparam logic [2:0] IMM_J    = 3'b100;
   localparam logic [2:0] IMM_NONE = 3'b111;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } dec_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  imm_sel;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [6:0]  opcode;
      logic        illegal;
   } dec_entry_t;

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator: sign-extends the immediate selected by imm_sel.
// Opcode bits are not needed here, so only instr[31:7] is taken.
module imm_gen
   import rv32i_pkg::*;
(
   input  logic [31:7] instr,
   input  logic [2:0]  imm_sel,
   output logic [31:0] imm
);

   // Immediate assembly per instruction format; unknown selects give zero.
   always_comb begin
      imm = 32'h0000_0000;
      case (imm_sel)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'h000};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/id_decode_stage.sv
// RV32I decode stage: classifies the fetched opcode, drives imm_gen and holds
// decoded entries in a main + skid register pair toward execute.
module id_decode_stage
   import rv32i_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_imm,
   output logic [2:0]      out_imm_sel,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [6:0]      out_opcode,
   output logic            out_illegal
);

   localparam dec_entry_t RESET_ENTRY = '{
      pc: RESET_PC, imm: 32'h0000_0000, imm_sel: 3'b000, rs1: 5'd0,
      rs2: 5'd0, rd: 5'd0, opcode: 7'd0, illegal: 1'b0
   };

   dec_state_e state_r, state_nx_s;
   dec_entry_t main_r, main_nx_s;
   dec_entry_t skid_r, skid_nx_s;
   dec_entry_t dec_s;
   logic [2:0]  imm_sel_s;
   logic        illegal_s;
   logic [31:0] imm_s;
   logic        in_fire_s;
   logic        out_fire_s;

   // Opcode classification; every supported opcode ends in 2'b11, so any
   // other low-bit pattern falls into the illegal default.
   always_comb begin
      imm_sel_s = IMM_NONE;
      illegal_s = 1'b0;
      case (in_instr[6:0])
         OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: imm_sel_s = IMM_I;
         OPC_STORE:             imm_sel_s = IMM_S;
         OPC_BRANCH:            imm_sel_s = IMM_B;
         OPC_LUI, OPC_AUIPC:    imm_sel_s = IMM_U;
         OPC_JAL:               imm_sel_s = IMM_J;
         OPC_OP:                imm_sel_s = IMM_NONE;
         default: begin
            imm_sel_s = IMM_NONE;
            illegal_s = 1'b1;
         end
      endcase
   end

   imm_gen u_imm_gen (
      .instr   (in_instr[31:7]),
      .imm_sel (imm_sel_s),
      .imm     (imm_s)
   );

   assign dec_s = '{
      pc: in_pc, imm: imm_s, imm_sel: imm_sel_s, rs1: in_instr[19:15],
      rs2: in_instr[24:20], rd: in_instr[11:7], opcode: in_instr[6:0],
      illegal: illegal_s
   };

   // Handshake depends only on the registered state, never on out_ready.
   assign in_ready   = (state_r != TWO);
   assign out_valid  = (state_r != EMPTY);
   assign in_fire_s  = in_valid & in_ready;
   assign out_fire_s = out_valid & out_ready;

   // Next-state and entry movement; flush overrides every transition.
   always_comb begin
      state_nx_s = state_r;
      main_nx_s  = main_r;
      skid_nx_s  = skid_r;
      if (flush) begin
         state_nx_s = EMPTY;
      end else begin
         case (state_r)
            EMPTY: begin
               if (in_fire_s) begin
                  state_nx_s = ONE;
                  main_nx_s  = dec_s;
               end else begin
                  state_nx_s = EMPTY;
               end
            end
            ONE: begin
               if (in_fire_s && out_fire_s) begin
                  main_nx_s = dec_s;
               end else if (in_fire_s) begin
                  state_nx_s = TWO;
                  skid_nx_s  = dec_s;
               end else if (out_fire_s) begin
                  state_nx_s = EMPTY;
               end else begin
                  state_nx_s = ONE;
               end
            end
            TWO: begin
               if (out_fire_s) begin
                  state_nx_s = ONE;
                  main_nx_s  = skid_r;
               end else begin
                  state_nx_s = TWO;
               end
            end
            default: state_nx_s = EMPTY;
         endcase
      end
   end

   // State and entry registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= EMPTY;
         main_r  <= RESET_ENTRY;
         skid_r  <= RESET_ENTRY;
      end else begin
         state_r <= state_nx_s;
         main_r  <= main_nx_s;
         skid_r  <= skid_nx_s;
      end
   end

   assign out_pc      = main_r.pc;
   assign out_imm     = main_r.imm;
   assign out_imm_sel = main_r.imm_sel;
   assign out_rs1     = main_r.rs1;
   assign out_rs2     = main_r.rs2;
   assign out_rd      = main_r.rd;
   assign out_opcode  = main_r.opcode;
   assign out_illegal = main_r.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed decode vectors plus a
// queue-based reference of the 2-deep FIFO under random handshakes.
module tb_id_decode_stage;
   import rv32i_pkg::*;

   localparam logic [31:0] RPC = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
   logic [31:0] in_pc, in_instr, out_pc, out_imm;
   logic [2:0]  out_imm_sel;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [6:0]  out_opcode;
   dec_entry_t  obs;

   int checks = 0;
   int failures = 0;
   dec_entry_t model_q[$];
   logic in_fire_m, out_fire_m;

   always #5 clk = ~clk;

   id_decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_imm(out_imm), .out_imm_sel(out_imm_sel), .out_rs1(out_rs1),
      .out_rs2(out_rs2), .out_rd(out_rd), .out_opcode(out_opcode), .out_illegal(out_illegal)
   );

   assign obs = {out_pc, out_imm, out_imm_sel, out_rs1, out_rs2, out_rd, out_opcode, out_illegal};

   // Reference decode built from the RV32I field weights with integer arithmetic.
   function automatic dec_entry_t ref_decode(input logic [31:0] pc, input logic [31:0] ins);
      dec_entry_t e;
      longint v;
      e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      e.opcode = ins[6:0]; e.illegal = 1'b0; e.imm_sel = 3'd7; v = 0;
      case (int'(ins[6:0]))
         3, 15, 19, 103, 115: begin
            e.imm_sel = 3'd0; v = longint'(ins[30:20]) - longint'(ins[31]) * 2048;
         end
         35: begin
            e.imm_sel = 3'd1;
            v = longint'(ins[11:7]) + longint'(ins[30:25]) * 32 - longint'(ins[31]) * 2048;
         end
         99: begin
            e.imm_sel = 3'd2;
            v = longint'(ins[11:8]) * 2 + longint'(ins[30:25]) * 32
              + longint'(ins[7]) * 2048 - longint'(ins[31]) * 4096;
         end
         23, 55: begin e.imm_sel = 3'd3; v = longint'(ins[31:12]) * 4096; end
         111: begin
            e.imm_sel = 3'd4;
            v = longint'(ins[30:21]) * 2 + longint'(ins[20]) * 2048
              + longint'(ins[19:12]) * 4096 - longint'(ins[31]) * 1048576;
         end
         51: e.imm_sel = 3'd7;
         default: e.illegal = 1'b1;
      endcase
      e.imm = v[31:0];
      return e;
   endfunction

   // Drives one cycle of inputs and advances the reference queue.
   task automatic cycle(input logic iv, input logic [31:0] ipc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
      in_valid = iv; in_pc = ipc; in_instr = ins; out_ready = ordy; flush = fl;
      in_fire_m  = iv && (model_q.size() < 2);
      out_fire_m = ordy && (model_q.size() > 0);
      @(posedge clk); #1;
      if (out_fire_m) void'(model_q.pop_front());
      if (fl) model_q.delete();
      else if (in_fire_m) model_q.push_back(ref_decode(ipc, ins));
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = 32'h0; in_instr = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_hs got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
      end
      checks++;
      if (obs !== {RPC, 32'h0, 3'd0, 5'd0, 5'd0, 5'd0, 7'd0, 1'b0}) begin
         failures++; $display("FAIL reset_out got=%h exp pc=%h rest 0", obs, RPC);
      end
   endtask

   task automatic test_decode();
      logic [31:0] ins_t [6] = '{32'hFFF00093, 32'hFE112E23, 32'h123452B7,
                                 32'h00000000, 32'h0000007F, 32'h00000033};
      logic [31:0] imm_t [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h0, 32'h0, 32'h0};
      logic [2:0]  sel_t [6] = '{3'd0, 3'd1, 3'd3, 3'd7, 3'd7, 3'd7};
      logic        ill_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [4:0]  rd_t  [6] = '{5'd1, 5'd28, 5'd5, 5'd0, 5'd0, 5'd0};
      logic [4:0]  rs1_t [6] = '{5'd0, 5'd2, 5'd8, 5'd0, 5'd0, 5'd0};
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 32'h100 + 32'(i * 4), ins_t[i], 1'b1, 1'b0);
         checks++;
         if (out_valid !== 1'b1 || out_imm !== imm_t[i] || out_imm_sel !== sel_t[i] ||
             out_illegal !== ill_t[i] || out_rd !== rd_t[i] || out_rs1 !== rs1_t[i] ||
             out_pc !== 32'h100 + 32'(i * 4)) begin
            failures++;
            $display("FAIL decode[%0d] got v=%b imm=%h sel=%0d ill=%b rd=%0d rs1=%0d pc=%h exp imm=%h sel=%0d ill=%b rd=%0d rs1=%0d",
                     i, out_valid, out_imm, out_imm_sel, out_illegal, out_rd, out_rs1, out_pc,
                     imm_t[i], sel_t[i], ill_t[i], rd_t[i], rs1_t[i]);
         end
      end
      checks++;
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL decode_drain got v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc [5] = '{32'hA00, 32'hA00, 32'hA00, 32'hB00, 32'hC00};
      logic        exp_rdy[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic        ordy   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [31:0] ipc    [5] = '{32'hA00, 32'hB00, 32'hC00, 32'hC00, 32'hC00};
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, ipc[i], 32'h00A00513 + 32'(i << 7), ordy[i], 1'b0);
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || in_ready !== exp_rdy[i] ||
             obs !== model_q[0]) begin
            failures++;
            $display("FAIL bp[%0d] got v=%b pc=%h rdy=%b exp pc=%h rdy=%b", i, out_valid, out_pc,
                     in_ready, exp_pc[i], exp_rdy[i]);
         end
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL bp_drain got v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_flush();
      cycle(1'b1, 32'hD00, 32'h00100093, 1'b0, 1'b0);
      cycle(1'b1, 32'hD04, 32'h00200093, 1'b0, 1'b0);
      checks++;
      if (in_ready !== 1'b0) begin
         failures++; $display("FAIL flush_fill got rdy=%b exp 0", in_ready);
      end
      cycle(1'b1, 32'hD08, 32'h00300093, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL flush got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL flush_leak got v=%b pc=%h exp v=0", out_valid, out_pc);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                               7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
      int sent = 0;
      int cyc = 0;
      logic [31:0] pc = 32'h2000;
      logic [31:0] ins;
      logic fl;
      while (sent < 1000 && cyc < 20000) begin
         ins = $urandom;
         if ($urandom_range(0, 3) != 0) ins[6:0] = ops[$urandom_range(0, 10)];
         fl = ($urandom_range(0, 63) == 0);
         cycle($urandom_range(0, 3) != 0, pc, ins, $urandom_range(0, 2) != 0, fl);
         if (in_fire_m) begin sent++; pc = pc + 32'd4; end
         cyc++;
         checks++;
         if (in_ready !== (model_q.size() < 2) || out_valid !== (model_q.size() > 0) ||
             (model_q.size() > 0 && obs !== model_q[0])) begin
            failures++;
            $display("FAIL random cyc=%0d got v=%b rdy=%b out=%h exp n=%0d", cyc, out_valid,
                     in_ready, obs, model_q.size());
         end
      end
      checks++;
      if (sent < 1000) begin
         failures++; $display("FAIL random_budget got sent=%0d exp 1000", sent);
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, 32'h8000 + 32'(i * 4), 32'h00000013, 1'b1, 1'b0);
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'h8000 + 32'(i * 4)) begin
            failures++;
            $display("FAIL stream[%0d] got rdy=%b v=%b pc=%h exp rdy=1 v=1 pc=%h", i, in_ready,
                     out_valid, out_pc, 32'h8000 + 32'(i * 4));
         end
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_async_reset();
      cycle(1'b1, 32'hE00, 32'hFFF00093, 1'b0, 1'b0);
      cycle(1'b1, 32'hE04, 32'hFE112E23, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
          obs !== {RPC, 32'h0, 3'd0, 5'd0, 5'd0, 5'd0, 7'd0, 1'b0}) begin
         failures++;
         $display("FAIL async_rst got v=%b rdy=%b out=%h exp v=0 rdy=1 pc=%h", out_valid,
                  in_ready, obs, RPC);
      end
      model_q.delete();
      in_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL async_rst_after got v=%b exp 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_backpressure();
      test_flush();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
